sample_scheduler: RTL
=====================

// Module: sample_scheduler
// PURPOSE
//  Stereo sample buffer and playback sequencer in the clk domain. Sits between control_unit and dsp_unit.
//  Buffers APB-written stereo frames in a FIFO and releases one frame per sink request (req_in from cdc_unit).
//  Requests refill from software via irq_out, and handles prime, underrun and overflow conditions.
// PARAMETERS
//  FIFO_DEPTH  8   entries, power of 2, >=4; one entry = {audio1,audio0}
//  AUDIO_W     24  bits per channel sample
//  LVL_W       $clog2(FIFO_DEPTH)+1  level/threshold width (derived, localparam)
// PORTS
//  clk          in   1        system clock; sole clock
//  rst          in   1        synchronous reset, active-high
//  play_in      in   1        playback enable (level)
//  clr_in       in   1        flush FIFO, clear flags (1-cycle pulse)
//  wr_in        in   1        push {audio1_in,audio0_in}
//  audio0_in    in   AUDIO_W  left sample to push
//  audio1_in    in   AUDIO_W  right sample to push
//  thresh_in    in   LVL_W    low-watermark for irq_out
//  req_in       in   1        sink frame request (1-cycle pulse)
//  tick_out     out  1        frame valid strobe to dsp_unit (1 cycle)
//  audio0_out   out  AUDIO_W  left frame out, held between ticks
//  audio1_out   out  AUDIO_W  right frame out, held between ticks
//  level_out    out  LVL_W    current FIFO occupancy 0..FIFO_DEPTH
//  full_out     out  1        level_out==FIFO_DEPTH
//  irq_out      out  1        refill request (level)
//  underrun_out out  1        sticky: req served from empty FIFO
//  overflow_out out  1        sticky: push attempted while full
// BEHAVIOUR
//  - rst=1 at posedge: all outputs 0, pointers 0, state IDLE. FIFO storage need not reset.
//  - FSM sched_state_t: IDLE, PRIME, RUN.
//    IDLE: req_in ignored, no tick. Goes to PRIME on play_in=1.
//    PRIME: req_in ignored. Goes to RUN when level==FIFO_DEPTH. Returns to IDLE on play_in=0.
//    RUN: serves requests. Returns to IDLE on play_in=0; FIFO contents retained.
//  - clr_in has priority over everything except rst.
//    Next cycle: level 0, sticky flags 0, state IDLE, outputs audio held.
//  - Push: wr_in & !full -> store at wptr, wptr wraps mod FIFO_DEPTH.
//    wr_in & full & !pop -> dropped, overflow_out<=1.
//  - Pop (RUN & req_in & level>0):
//    Cycle N+1: tick_out=1; audio*_out = head frame. Latency is exactly 1 cycle.
//  - Underrun (RUN & req_in & level==0):
//    Cycle N+1: tick_out=1, audio*_out=0, underrun_out<=1.
//  - Simultaneous push+pop:
//    Nonempty: both occur, level unchanged, no overflow even if full.
//    Empty: underrun, and the push lands (level becomes 1).
//  - level_out, full_out and irq_out are registered and reflect post-update occupancy.
//  - irq_out = (state!=IDLE) && (level <= thresh_in). With thresh_in>=FIFO_DEPTH it is constantly high when not IDLE.
//  - req_in while tick pending: each req_in pulse yields exactly one tick; back-to-back reqs give back-to-back ticks.
// CONFIGURATION
//  SCHED_REPEAT_ON_UNDERRUN_EN defined:
//    On underrun, audio*_out repeat the last delivered frame (0 if none since reset/clr) instead of 0.
//    underrun_out still sets.
//  Not defined: underrun outputs zeros as above.
// STRUCTURE
//  audioport_pkg: sched_state_t enum; typedef stereo_frame_t = struct {audio1,audio0} of AUDIO_W; SCHED_FIFO_DEPTH=8.
//  Sub-module sample_fifo: storage, pointers and level.
//    Ports: clk, rst, clr, push, pop, din, dout, level, full, empty.
//  Top owns the FSM, output registers and flags.
// TESTING
//  1 Reset/idle: rst then play_in=0, req_in pulses -> tick_out never 1; all outputs 0.
//  2 Prime/run: thresh_in=2, push 8 frames (0x000001..0x000008 L, 0x100001.. R), play_in=1 -> RUN;
//    8 reqs -> 8 ticks, each 1 cycle after req, frames in order; irq_out rises when level reaches 2.
//  3 Underrun: RUN with level 0, req_in -> tick next cycle, audio 0x000000 (0x000008 with SCHED_REPEAT_ON_UNDERRUN_EN), underrun_out=1.
//  4 Overflow/simultaneous: full FIFO, wr_in alone -> overflow_out=1, level 8;
//    wr_in+req_in same cycle -> level stays 8, overflow unchanged.
//  5 Clear mid-run: clr_in during RUN with level 5 and req_in same cycle -> no tick, level 0, flags 0, state IDLE.
//  6 Wrap: push/pop 3*FIFO_DEPTH frames with level kept 1..3 -> data order exact across pointer wrap.

Source files
------------

// File: rtl/audioport_pkg.sv
// Shared types and constants for the audio-port sample scheduler and its FIFO.
package audioport_pkg;

   localparam int SCHED_FIFO_DEPTH = 8;
   localparam int SCHED_AUDIO_W    = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic [SCHED_AUDIO_W-1:0] audio1;
      logic [SCHED_AUDIO_W-1:0] audio0;
   } stereo_frame_t;

endpackage

// File: rtl/sample_fifo.sv
// Stereo frame FIFO: storage, wrapping pointers and registered occupancy flags.
module sample_fifo
   import audioport_pkg::*;
#(
   parameter  int DEPTH = SCHED_FIFO_DEPTH,
   parameter  int DW    = 2 * SCHED_AUDIO_W,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [LW-1:0] level_r;
   logic [LW-1:0] level_s;
   logic          full_r;
   logic          empty_r;

   // Occupancy after this cycle's push/pop.
   always_comb begin
      level_s = level_r;
      if (push && !pop) begin
         level_s = level_r + LW'(1);
      end else if (pop && !push) begin
         level_s = level_r - LW'(1);
      end else begin
         level_s = level_r;
      end
   end

   // Frame storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wptr_r] <= din;
      end
   end

   // Pointers and occupancy flags.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wptr_r  <= {AW{1'b0}};
         rptr_r  <= {AW{1'b0}};
         level_r <= {LW{1'b0}};
         full_r  <= 1'b0;
         empty_r <= 1'b1;
      end else begin
         if (push) begin
            wptr_r <= wptr_r + AW'(1);
         end
         if (pop) begin
            rptr_r <= rptr_r + AW'(1);
         end
         level_r <= level_s;
         full_r  <= (level_s == LW'(DEPTH));
         empty_r <= (level_s == {LW{1'b0}});
      end
   end

   assign dout  = mem_r[rptr_r];
   assign level = level_r;
   assign full  = full_r;
   assign empty = empty_r;

endmodule

// File: rtl/sample_scheduler.sv
// Stereo sample scheduler: buffers frames and releases one per sink request.
// Build option SCHED_REPEAT_ON_UNDERRUN_EN repeats the last delivered frame on underrun.
module sample_scheduler
   import audioport_pkg::*;
#(
   parameter  int FIFO_DEPTH = SCHED_FIFO_DEPTH,
   parameter  int AUDIO_W    = SCHED_AUDIO_W,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               play_in,
   input  logic               clr_in,
   input  logic               wr_in,
   input  logic [AUDIO_W-1:0] audio0_in,
   input  logic [AUDIO_W-1:0] audio1_in,
   input  logic [LVL_W-1:0]   thresh_in,
   input  logic               req_in,
   output logic               tick_out,
   output logic [AUDIO_W-1:0] audio0_out,
   output logic [AUDIO_W-1:0] audio1_out,
   output logic [LVL_W-1:0]   level_out,
   output logic               full_out,
   output logic               irq_out,
   output logic               underrun_out,
   output logic               overflow_out
);

   localparam int FRAME_W = 2 * AUDIO_W;

   sched_state_t       state_r;
   sched_state_t       state_s;
   logic               push_s;
   logic               pop_s;
   logic               under_s;
   logic               ovf_s;
   logic               empty_s;
   logic               full_s;
   logic [LVL_W-1:0]   lvl_s;
   logic [LVL_W-1:0]   lvl_next_s;
   logic [FRAME_W-1:0] head_s;
   logic [FRAME_W-1:0] under_frame_s;
   logic [FRAME_W-1:0] audio_r;
   logic               tick_r;
   logic               irq_r;
   logic               underrun_r;
   logic               overflow_r;

   sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (FRAME_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_in),
      .push  (push_s),
      .pop   (pop_s),
      .din   ({audio1_in, audio0_in}),
      .dout  (head_s),
      .level (lvl_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Request/push decode; a pop frees the slot a same-cycle push needs.
   always_comb begin
      pop_s   = 1'b0;
      under_s = 1'b0;
      push_s  = 1'b0;
      ovf_s   = 1'b0;
      if (clr_in) begin
         pop_s   = 1'b0;
         under_s = 1'b0;
      end else begin
         pop_s   = (state_r == RUN) && req_in && !empty_s;
         under_s = (state_r == RUN) && req_in && empty_s;
         push_s  = wr_in && (!full_s || pop_s);
         ovf_s   = wr_in && full_s && !pop_s;
      end
   end

   // Post-update occupancy, used so irq_out tracks the level it is registered with.
   always_comb begin
      lvl_next_s = lvl_s;
      if (clr_in) begin
         lvl_next_s = {LVL_W{1'b0}};
      end else if (push_s && !pop_s) begin
         lvl_next_s = lvl_s + LVL_W'(1);
      end else if (pop_s && !push_s) begin
         lvl_next_s = lvl_s - LVL_W'(1);
      end else begin
         lvl_next_s = lvl_s;
      end
   end

   // Sequencer next state.
   always_comb begin
      state_s = state_r;
      if (clr_in) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    state_s = play_in ? PRIME : IDLE;
            PRIME:   state_s = !play_in ? IDLE : (full_s ? RUN : PRIME);
            RUN:     state_s = play_in ? RUN : IDLE;
            default: state_s = IDLE;
         endcase
      end
   end

`ifdef SCHED_REPEAT_ON_UNDERRUN_EN
   logic [FRAME_W-1:0] last_r;

   // Last frame actually delivered, forgotten on clear.
   always_ff @(posedge clk) begin
      if (rst || clr_in) begin
         last_r <= {FRAME_W{1'b0}};
      end else if (pop_s) begin
         last_r <= head_s;
      end
   end

   assign under_frame_s = last_r;
`else
   assign under_frame_s = {FRAME_W{1'b0}};
`endif

   // State, frame strobe, held audio and refill request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         tick_r  <= 1'b0;
         audio_r <= {FRAME_W{1'b0}};
         irq_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         tick_r  <= pop_s || under_s;
         if (pop_s) begin
            audio_r <= head_s;
         end else if (under_s) begin
            audio_r <= under_frame_s;
         end
         irq_r <= (state_s != IDLE) && (lvl_next_s <= thresh_in);
      end
   end

   // Sticky error flags.
   always_ff @(posedge clk) begin
      if (rst || clr_in) begin
         underrun_r <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         if (under_s) begin
            underrun_r <= 1'b1;
         end
         if (ovf_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   assign tick_out     = tick_r;
   assign audio1_out   = audio_r[FRAME_W-1:AUDIO_W];
   assign audio0_out   = audio_r[AUDIO_W-1:0];
   assign level_out    = lvl_s;
   assign full_out     = full_s;
   assign irq_out      = irq_r;
   assign underrun_out = underrun_r;
   assign overflow_out = overflow_r;

endmodule
